// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-comparison helper for the sync_fifo_param slice.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATASIZE = 8;
  localparam int unsigned DEF_ADDRSIZE = 4;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  // Pointers carry one wrap bit above an aw-bit address, zero-extended to 32 bits.
  function automatic ptr_flags_t ptr_compare(input logic [31:0] wptr,
                                             input logic [31:0] rptr,
                                             input int unsigned aw);
    logic [31:0] diff;
    logic [31:0] lo_mask;
    ptr_flags_t  f;
    diff    = wptr ^ rptr;
    lo_mask = (32'd1 << aw) - 32'd1;
    f.full  = ((diff & lo_mask) == '0) && ((diff & (32'd1 << aw)) != '0);
    f.empty = (diff & ((lo_mask << 1) | 32'd1)) == '0;
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: dual-port array, synchronous write, combinational read.
module sync_fifo_mem #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [0:(1<<ADDRSIZE)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with registered flags, occupancy count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered rdata.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE   = DEF_DATASIZE,
  parameter int unsigned ADDRSIZE   = DEF_ADDRSIZE,
  parameter int unsigned AFULL_LVL  = (1 << ADDRSIZE) - 2,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [ADDRSIZE:0] AFULL_THR  = (ADDRSIZE+1)'(AFULL_LVL);
  localparam logic [ADDRSIZE:0] AEMPTY_THR = (ADDRSIZE+1)'(AEMPTY_LVL);

  logic [ADDRSIZE:0]   wptr_q, wptr_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic                wfull_q, wfull_d;
  logic                rempty_q, rempty_d;
  logic                walmost_full_q, walmost_full_d;
  logic                ralmost_empty_q, ralmost_empty_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_acc, rd_acc, mem_we;
  logic [DATASIZE-1:0] mem_rdata;
  ptr_flags_t          flags_d;

  sync_fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q[ADDRSIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ADDRSIZE-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_acc      = winc && !wfull_q;
    rd_acc      = rinc && !rempty_q;
    mem_we      = wr_acc && !clr;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (winc && wfull_q)  overflow_d  = 1'b1;
      if (rinc && rempty_q) underflow_d = 1'b1;
    end
    // Flags are derived from next-state pointers so they register in step with them.
    count_d         = wptr_d - rptr_d;
    flags_d         = ptr_compare(32'(wptr_d), 32'(rptr_d), ADDRSIZE);
    wfull_d         = flags_d.full;
    rempty_d        = flags_d.empty;
    walmost_full_d  = count_d >= AFULL_THR;
    ralmost_empty_d = count_d <= AEMPTY_THR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is masked while empty so reset presents zero.
  assign rdata = rempty_q ? '0 : mem_rdata;
`else
  logic [DATASIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc && !clr) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = walmost_full_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model plus directed and random stimulus.
// Honours SYNC_FIFO_FWFT_EN when the design is built with it.
module tb_sync_fifo_param;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AFULL  = 14;
  localparam int unsigned AEMPTY = 2;

  logic       clk = 1'b0;
  logic       rst_n, clr, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_rdata;

  sync_fifo_param #(
    .DATASIZE   (8),
    .ADDRSIZE   (4),
    .AFULL_LVL  (AFULL),
    .AEMPTY_LVL (AEMPTY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the FIFO's acceptance rules.
  always @(posedge clk or negedge rst_n) begin : model
    bit full, empty;
    if (!rst_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = 8'h00;
    end else if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      if (winc && full)  m_ovf = 1'b1;
      if (rinc && empty) m_udf = 1'b1;
      if (rinc && !empty) m_rdata = mq.pop_front();
      if (winc && !full)  mq.push_back(wdata);
    end
  end

  always @(negedge clk) begin : compare
    int unsigned n;
    n = mq.size();
    check("count", count, n);
    check("wfull", wfull, (n == DEPTH) ? 1 : 0);
    check("rempty", rempty, (n == 0) ? 1 : 0);
    check("walmost_full", walmost_full, (n >= AFULL) ? 1 : 0);
    check("ralmost_empty", ralmost_empty, (n <= AEMPTY) ? 1 : 0);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
`ifdef SYNC_FIFO_FWFT_EN
    if (n != 0) check("rdata_head", rdata, mq[0]);
`else
    check("rdata", rdata, m_rdata);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_rw(input bit w, input logic [7:0] wd, input bit r,
                          input bit chk, input logic [7:0] exp);
    winc  = w;
    wdata = wd;
    rinc  = r;
`ifdef SYNC_FIFO_FWFT_EN
    if (chk) check("rdata_lit", rdata, exp);
`endif
    tick();
    winc = 1'b0;
    rinc = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    if (chk) check("rdata_lit", rdata, exp);
`endif
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      cycle_rw(1'b1, base + 8'(i), 1'b0, 1'b0, 8'h00);
      check("fill_count", count, i + 1);
      check("fill_afull", walmost_full, (i + 1 >= 14) ? 1 : 0);
    end
    check("fill_wfull", wfull, 1);
  endtask

  task automatic drain(input logic [7:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) cycle_rw(1'b0, 8'h00, 1'b1, 1'b1, base + 8'(i));
  endtask

  initial begin
    int unsigned pw;
    rst_n = 1'b0; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_rempty", rempty, 1);
    check("rst_raempty", ralmost_empty, 1);
    check("rst_wfull", wfull, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;

    fill(8'h00);
    check("full_count16", count, 16);
    cycle_rw(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    drain(8'h00, 16);
    check("drain_rempty", rempty, 1);
    check("drain_count", count, 0);
    fill(8'h00);
    drain(8'h00, 16);
    check("wrap_rempty", rempty, 1);

    for (int i = 0; i < 8; i++) cycle_rw(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle_rw(1'b1, 8'h50 + 8'(i), 1'b1, 1'b1,
               (i < 8) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 8));
      check("rw_count8", count, 8);
    end
    drain(8'h52, 8);

    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ovf", overflow, 0);
    fill(8'h60);
    for (int i = 0; i < 3; i++) begin
      cycle_rw(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
      check("ovf_sticky", overflow, 1);
    end
    clr = 1'b1; winc = 1'b1; rinc = 1'b1;
    tick();
    clr = 1'b0; winc = 1'b0; rinc = 1'b0;
    check("clr2_ovf", overflow, 0);
    check("clr2_rempty", rempty, 1);
    check("clr2_count", count, 0);
    check("clr2_raempty", ralmost_empty, 1);

    for (int i = 0; i < 3; i++) begin
      cycle_rw(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      check("udf_set", underflow, 1);
      check("udf_count", count, 0);
    end
    winc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'h30 + 8'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_rempty", rempty, 1);
    check("mid_rst_raempty", ralmost_empty, 1);
    check("mid_rst_wfull", wfull, 0);
    check("mid_rst_afull", walmost_full, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_udf", underflow, 0);
    check("mid_rst_rdata", rdata, 0);
    winc = 1'b0;
    tick();
    rst_n = 1'b1;
    cycle_rw(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    check("first_wr_count", count, 1);
    check("first_wr_rempty", rempty, 0);
    drain(8'h77, 1);

`ifdef SYNC_FIFO_FWFT_EN
    clr = 1'b1; tick(); clr = 1'b0;
    cycle_rw(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("fwft_rdata", rdata, 8'hA5);
      check("fwft_rempty0", rempty, 0);
      tick();
    end
    cycle_rw(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("fwft_rempty1", rempty, 1);
`endif

    pw = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) pw = $urandom_range(2, 0) * 30 + 20;
      winc  = ($urandom_range(99, 0) < pw);
      rinc  = ($urandom_range(99, 0) < (100 - pw));
      wdata = 8'($urandom);
      clr   = ($urandom_range(149, 0) == 0);
      tick();
    end
    winc = 1'b0; rinc = 1'b0; clr = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATASIZE, default 8: data word width in bits.
REQ-002 Parameter ADDRSIZE, default 4: address width; depth = 2**ADDRSIZE.
REQ-003 Parameter AFULL_LVL, default 2**ADDRSIZE-2: occupancy at or above which walmost_full asserts.
REQ-004 Parameter AEMPTY_LVL, default 2: occupancy at or below which ralmost_empty asserts.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous flush of pointers, count and sticky flags.
REQ-008 winc  input  1  write request.
REQ-009 wdata  input  DATASIZE  write data.
REQ-010 rinc  input  1  read request.
REQ-011 rdata  output  DATASIZE  read data.
REQ-012 wfull, rempty  output  1 each  full and empty flags.
REQ-013 walmost_full, ralmost_empty  output  1 each  threshold flags.
REQ-014 count  output  ADDRSIZE+1  current occupancy, 0..2**ADDRSIZE.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted iff winc && !wfull; wdata stored at waddr; waddr increments modulo depth.
REQ-017 Read accepted iff rinc && !rempty; raddr increments modulo depth.
REQ-018 Pointers are ADDRSIZE+1 bits; full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
REQ-019 count, wfull, rempty, walmost_full and ralmost_empty are registered; each reflects the accepted operations one cycle after the edge.
REQ-020 Accepted write and read in the same cycle: count unchanged, both pointers advance.
REQ-021 While full, winc is rejected even if rinc is accepted in the same cycle; count decrements by 1.
REQ-022 While empty, rinc is rejected even if winc is accepted in the same cycle; count increments by 1.
REQ-023 winc while wfull sets overflow; rinc while rempty sets underflow; both flags hold until clr or reset.
REQ-024 clr has priority over winc and rinc in the same cycle.
REQ-025 clr zeroes the pointers, count, overflow and underflow, and forces rempty=1 and ralmost_empty=1; memory contents are not cleared.
REQ-026 walmost_full = (count >= AFULL_LVL); ralmost_empty = (count <= AEMPTY_LVL).

Reset
REQ-027 While rst_n=0, outputs take these values immediately: pointers 0, count 0, rempty 1, ralmost_empty 1, wfull 0, walmost_full 0, overflow 0, underflow 0, rdata 0.
REQ-028 Reset asserted mid-operation discards all contents.
REQ-029 The first accepted write is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN selects the read mode.
REQ-031 Without SYNC_FIFO_FWFT_EN: rdata is registered and updates on the edge that accepts a read, presenting the popped word; rdata holds otherwise.
REQ-032 With SYNC_FIFO_FWFT_EN: rdata continuously presents the head word whenever rempty=0, and an accepted read advances it to the next word in the same cycle.
REQ-033 With SYNC_FIFO_FWFT_EN: rdata is don't-care while rempty=1.

Structure
REQ-034 Package sync_fifo_pkg holds the default DATASIZE/ADDRSIZE constants and a pure function computing the full/empty comparison from two pointers.
REQ-035 Storage is sub-module sync_fifo_mem: a dual-port array with a synchronous write port and a combinational read port.
REQ-036 Pointer, count and flag logic lives in the top-level module.

Verification
REQ-037 Reset, then 16 writes of 0x00..0x0F (defaults) -> wfull=1 after the 16th edge, count=16, walmost_full=1 from count 14.
REQ-038 Full FIFO, then 16 reads -> data 0x00..0x0F in order, rempty=1, count=0; repeated twice to exercise pointer wrap.
REQ-039 count=8, winc=rinc=1 for 10 cycles -> count stays 8, data order preserved.
REQ-040 Full FIFO with winc=1 and rinc=0 -> overflow=1 persists; then clr -> overflow=0, rempty=1, count=0.
REQ-041 Empty FIFO with rinc=1 -> underflow=1 and count stays 0; then assert rst_n=0 mid-burst -> all outputs match REQ-027 immediately.
REQ-042 Build with SYNC_FIFO_FWFT_EN, write 0xA5 -> rdata=0xA5 while rempty=0 with no rinc; one rinc -> rempty=1.
